ex_muldiv_unit: RTL and testbench

Iterative 16-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register's operand, destination and control outputs. While an operation runs it raises a stall request that freezes ID/EX and the stages upstream of it. It produces one registered result per accepted operation, which the EX/MEM path captures in the cycle after completion.

---
 rtl/ex_muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_iter_step.sv | 42 ++++
 rtl/ex_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operation encodings, FSM states and default datapath sizing.
package ex_muldiv_unit_pkg;

    localparam int unsigned MD_WIDTH = 16;
    localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULL = 2'b00,
        OP_MULH = 2'b01,
        OP_DIVQ = 2'b10,
        OP_DIVR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the unsigned multiply/divide datapath:
// LSB-first shift-add for MUL, restoring shift-subtract for DIV.
module muldiv_iter_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   add_sel;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        add_sum = {1'b0, acc_hi} + {1'b0, operand};
        add_sel = acc_lo[0] ? add_sum : {1'b0, acc_hi};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        // Extra bit keeps the borrow distinct from a 17-bit partial remainder,
        // which occurs when the divisor is zero.
        diff    = {1'b0, shifted} - {2'b00, operand};
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            nxt_hi = add_sel[WIDTH:1];
            nxt_lo = {add_sel[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative 16-bit multiply/divide unit: sign handling, iteration
// control, pipeline stall request and registered result.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned REG_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Flush,
    input  logic [1:0]       Op,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    input  logic [REG_W-1:0] Rd_In,
    output logic             Stall_Req,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result_Out,
    output logic [REG_W-1:0] Rd_Out,
    output logic             DivZero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               neg_q, neg_d;
    logic               dz_pend_q, dz_pend_d;
    logic [REG_W-1:0]   rd_pend_q, rd_pend_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               divzero_q, divzero_d;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, final_res;

    muldiv_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (op_q[1]),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    always_comb begin
        a_neg = Signed & A_In[WIDTH-1];
        b_neg = Signed & B_In[WIDTH-1];
        a_mag = a_neg ? -A_In : A_In;
        b_mag = b_neg ? -B_In : B_In;
    end

    // Result selection uses the final iteration's output so it registers on E16.
    always_comb begin
        prod_mag = {step_hi, step_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        quot_fix = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi : step_hi;
        case (op_q)
            OP_MULL: final_res = prod_fix[WIDTH-1:0];
            OP_MULH: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIVQ: final_res = dz_pend_q ? '1 : quot_fix;
            default: final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        dz_pend_d = dz_pend_q;
        rd_pend_d = rd_pend_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rd_d      = rd_q;
        divzero_d = divzero_q;
        case (state_q)
            IDLE: begin
                if (Start && !Flush) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    op_d      = op_e'(Op);
                    neg_d     = (op_e'(Op) == OP_DIVR) ? a_neg : (a_neg ^ b_neg);
                    dz_pend_d = Op[1] && (B_In == '0);
                    rd_pend_d = Rd_In;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                    opnd_d    = b_mag;
                end
            end
            CALC: begin
                if (Flush) begin
                    state_d = IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        result_d  = final_res;
                        rd_d      = rd_pend_q;
                        divzero_d = dz_pend_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC) || (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULL;
            neg_q     <= 1'b0;
            dz_pend_q <= 1'b0;
            rd_pend_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            dz_pend_q <= dz_pend_d;
            rd_pend_q <= rd_pend_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            divzero_q <= divzero_d;
        end
    end

    assign Stall_Req  = ((state_q == IDLE) && Start && !Flush) || (state_q == CALC);
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Result_Out = result_q;
    assign Rd_Out     = rd_q;
    assign DivZero    = divzero_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against a plain-arithmetic model.
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Flush;
    logic [1:0]  Op;
    logic        Signed;
    logic [15:0] A_In;
    logic [15:0] B_In;
    logic [2:0]  Rd_In;
    logic        Stall_Req;
    logic        Busy;
    logic        Done;
    logic [15:0] Result_Out;
    logic [2:0]  Rd_Out;
    logic        DivZero;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] last_res = 16'h0000;

    always #5 CLK = ~CLK;

    ex_muldiv_unit #(
        .WIDTH (16),
        .REG_W (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Flush      (Flush),
        .Op         (Op),
        .Signed     (Signed),
        .A_In       (A_In),
        .B_In       (B_In),
        .Rd_In      (Rd_In),
        .Stall_Req  (Stall_Req),
        .Busy       (Busy),
        .Done       (Done),
        .Result_Out (Result_Out),
        .Rd_Out     (Rd_Out),
        .DivZero    (DivZero)
    );

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] op, input logic sgn,
                                  output logic [15:0] res, output logic dz);
        longint sa, sb, p, q, r;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        dz = 1'b0;
        if (!op[1]) begin
            res = op[0] ? p[31:16] : p[15:0];
        end else if (b == 16'h0000) begin
            dz  = 1'b1;
            res = op[0] ? a : 16'hFFFF;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = op[0] ? r[15:0] : q[15:0];
        end
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic sgn, input logic [2:0] rd, input bit hold_start);
        logic [15:0] exp_res;
        logic        exp_dz;
        int          edges;
        int          stalls;
        bit          seen;
        model(a, b, op, sgn, exp_res, exp_dz);
        @(negedge CLK);
        A_In = a; B_In = b; Op = op; Signed = sgn; Rd_In = rd;
        Start = 1'b1; Flush = 1'b0;
        #1;
        edges = 0; stalls = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (Stall_Req) stalls++;
            if (Done) seen = 1;
            else begin
                @(posedge CLK); edges++;
                @(negedge CLK); #1;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL done_timeout: no Done after %0d edges, required Done within 40", edges);
        end
        n_cmp++;
        if (edges !== 17) begin
            n_bad++;
            $display("FAIL latency: got %0d edges, required 17", edges);
        end
        n_cmp++;
        if (stalls !== 17) begin
            n_bad++;
            $display("FAIL stall_cycles: got %0d, required 17", stalls);
        end
        n_cmp++;
        if (Result_Out !== exp_res) begin
            n_bad++;
            $display("FAIL result a=%h b=%h op=%0d s=%0d: got %h, required %h", a, b, op, sgn, Result_Out, exp_res);
        end
        n_cmp++;
        if (DivZero !== exp_dz) begin
            n_bad++;
            $display("FAIL divzero a=%h b=%h op=%0d: got %b, required %b", a, b, op, DivZero, exp_dz);
        end
        n_cmp++;
        if (Rd_Out !== rd) begin
            n_bad++;
            $display("FAIL rd_out: got %0d, required %0d", Rd_Out, rd);
        end
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_done: got %b, required 1", Busy);
        end
        if (!hold_start) Start = 1'b0;
        last_res = exp_res;
    endtask

    task automatic check_no_done(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK); #1;
            if (Done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL %s: got %0d Done pulses, required 0", tag, pulses);
        end
        n_cmp++;
        if (Result_Out !== last_res) begin
            n_bad++;
            $display("FAIL %s_hold: got %h, required %h", tag, Result_Out, last_res);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00; Signed = 1'b0;
        A_In = '0; B_In = '0; Rd_In = '0;
        #12;
        n_cmp++;
        if ({Stall_Req, Busy, Done, DivZero} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 0000", {Stall_Req, Busy, Done, DivZero});
        end
        n_cmp++;
        if (Result_Out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_result: got %h, required 0000", Result_Out);
        end
        n_cmp++;
        if (Rd_Out !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_rd: got %0d, required 0", Rd_Out);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_directed();
        do_op(16'h00FF, 16'h0101, 2'b00, 1'b0, 3'd1, 1'b0);
        do_op(16'h00FF, 16'h0101, 2'b01, 1'b0, 3'd2, 1'b0);
        do_op(16'hFFFE, 16'h7FFF, 2'b01, 1'b1, 3'd3, 1'b0);
        do_op(16'hFFFE, 16'h7FFF, 2'b00, 1'b1, 3'd4, 1'b0);
        do_op(16'hFFF9, 16'h0002, 2'b10, 1'b1, 3'd5, 1'b0);
        do_op(16'hFFF9, 16'h0002, 2'b11, 1'b1, 3'd6, 1'b0);
        do_op(16'h8000, 16'hFFFF, 2'b10, 1'b1, 3'd7, 1'b0);
        do_op(16'h8000, 16'hFFFF, 2'b11, 1'b1, 3'd0, 1'b0);
        do_op(16'h1234, 16'h0000, 2'b10, 1'b0, 3'd1, 1'b0);
        do_op(16'h1234, 16'h0000, 2'b11, 1'b0, 3'd2, 1'b0);
        do_op(16'hF234, 16'h0000, 2'b10, 1'b1, 3'd3, 1'b0);
        do_op(16'hF234, 16'h0000, 2'b11, 1'b1, 3'd4, 1'b0);
    endtask

    task automatic test_back_to_back_random();
        logic [15:0] a, b;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) b = 16'hFFFF;
            do_op(a, b, 2'($urandom), 1'($urandom), 3'($urandom), 1'b0);
        end
    endtask

    task automatic test_flush();
        @(negedge CLK);
        A_In = 16'h1111; B_In = 16'h0022; Op = 2'b00; Signed = 1'b0; Rd_In = 3'd6;
        Start = 1'b1; Flush = 1'b0;
        @(posedge CLK);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        Flush = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Flush = 1'b0; Start = 1'b0;
        #1;
        n_cmp++;
        if ({Stall_Req, Busy, Done} !== 3'b000) begin
            n_bad++;
            $display("FAIL flush_idle: got stall/busy/done=%b, required 000", {Stall_Req, Busy, Done});
        end
        check_no_done(20, "flush_no_done");
        do_op(16'd3, 16'd5, 2'b00, 1'b0, 3'd5, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        A_In = 16'h4321; B_In = 16'h0007; Op = 2'b10; Signed = 1'b0; Rd_In = 3'd7;
        Start = 1'b1; Flush = 1'b0;
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b0; Start = 1'b0;
        #1;
        n_cmp++;
        if ({Stall_Req, Busy, Done, DivZero} !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset_flags: got %b, required 0000", {Stall_Req, Busy, Done, DivZero});
        end
        n_cmp++;
        if ({Result_Out, Rd_Out} !== 19'h0) begin
            n_bad++;
            $display("FAIL async_reset_data: got result=%h rd=%0d, required 0/0", Result_Out, Rd_Out);
        end
        last_res = 16'h0000;
        @(negedge CLK);
        RST = 1'b1;
        do_op(16'h0123, 16'h0011, 2'b11, 1'b0, 3'd3, 1'b1);
        @(negedge CLK);
        Start = 1'b0;
        #1;
        n_cmp++;
        if ({Busy, Stall_Req} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_held_in_done: got busy/stall=%b, required 00", {Busy, Stall_Req});
        end
        check_no_done(20, "no_second_done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
